sad_engine: RTL

- Parametrised sum-of-absolute-differences engine: control FSM, address counter, read-latency pipeline and accumulator in one block.
- Issues one address per cycle to two external block memories (A and B), which share the address and return pixels after a fixed read latency.
- Accumulates |A-B| over N_PIX pixels and publishes the result with a done pulse.
- Sits between the motion-estimation controller (start/done) and the pixel RAMs.

---
 rtl/sad_pkg.sv | 18 +
 rtl/sad_absdiff.sv | 14 +
 rtl/sad_engine.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD engine.
package sad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } sad_state_e;

  localparam int unsigned SAD_N_PIX_DEFAULT = 256;

  // Overflow-free accumulator width for n_pix unsigned differences of pix_w bits.
  function automatic int unsigned sad_width(input int unsigned pix_w, input int unsigned n_pix);
    return pix_w + $clog2(n_pix);
  endfunction

endpackage

// File: rtl/sad_absdiff.sv
// Combinational unsigned absolute difference |a - b|.
module sad_absdiff #(
  parameter int unsigned PIX_W = 8
) (
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  output logic [PIX_W-1:0] d_o
);

  always_comb begin
    d_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
  end

endmodule

// File: rtl/sad_engine.sv
// Sum-of-absolute-differences engine: FSM, address counter, read-valid pipe
// and accumulator. Optional early termination: `define SAD_EARLY_TERM_EN.
module sad_engine
  import sad_pkg::*;
#(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned N_PIX   = SAD_N_PIX_DEFAULT,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned AW      = $clog2(N_PIX),
  parameter int unsigned SAD_W   = sad_width(PIX_W, N_PIX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SAD_W-1:0] thresh,
  output logic [AW-1:0]    addr,
  output logic             rd_en,
  input  logic [PIX_W-1:0] a_data,
  input  logic [PIX_W-1:0] b_data,
  output logic             busy,
  output logic             done,
  output logic             early,
  output logic [SAD_W-1:0] sad
);

  sad_state_e         state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic [MEM_LAT-1:0] vld_q, vld_d, vld_shift;
  logic [SAD_W-1:0]   acc_q, acc_d, acc_sum;
  logic [SAD_W-1:0]   sad_q, sad_d;
  logic [PIX_W-1:0]   diff;
  logic               acc_en;
  logic               trig;

  sad_absdiff #(.PIX_W(PIX_W)) u_absdiff (
    .a_i (a_data),
    .b_i (b_data),
    .d_o (diff)
  );

  assign acc_en    = vld_q[MEM_LAT-1];
  assign acc_sum   = acc_q + SAD_W'(diff);
  assign vld_shift = vld_q << 1;

  assign rd_en = (state_q == RUN);
  assign addr  = cnt_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign sad   = sad_q;

`ifdef SAD_EARLY_TERM_EN
  logic [SAD_W-1:0] thresh_q, thresh_d;
  logic             early_q, early_d;

  assign trig  = acc_en && (acc_sum > thresh_q);
  assign early = (state_q == DONE) && early_q;

  // Threshold capture at run start and sticky early-stop flag.
  always_comb begin
    thresh_d = thresh_q;
    early_d  = early_q;
    if (state_q == IDLE && start) begin
      thresh_d = thresh;
      early_d  = 1'b0;
    end
    if (trig) begin
      early_d = 1'b1;
    end
  end

  // Early-termination registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q <= '0;
      early_q  <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      early_q  <= early_d;
    end
  end
`else
  logic unused_thresh;

  assign unused_thresh = ^thresh;
  assign trig          = 1'b0;
  assign early         = 1'b0;
`endif

  // Next-state, counter, valid pipe and accumulator.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sad_d   = sad_q;
    vld_d   = vld_shift | MEM_LAT'(rd_en);
    if (acc_en) begin
      acc_d = acc_sum;
    end
    // An early stop discards every read still in flight.
    if (trig) begin
      vld_d = '0;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        if (trig || cnt_q == AW'(N_PIX - 1)) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      DRAIN: begin
        // Leave one cycle early: the final in-flight pixel is summed on this
        // edge, so sad is already valid in the DONE cycle.
        if (trig || vld_shift == '0) begin
          state_d = DONE;
          sad_d   = acc_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= '0;
      acc_q   <= '0;
      sad_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      acc_q   <= acc_d;
      sad_q   <= sad_d;
    end
  end

endmodule
